// File: rtl/apb_shared_master_pkg.sv
// rtl/apb_shared_master_pkg.sv - shared types and defaults for the APB shared master
package apb_shared_master_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // APB phase encoding; 2'b11 is never entered and falls back to IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

endpackage

// File: rtl/apb_shared_master_if.sv
// rtl/apb_shared_master_if.sv - requester and APB bus signals of the shared master
interface apb_shared_master_if
  import apb_shared_master_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;

  logic [AW-1:0]      PADDR;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [DW-1:0]      PWDATA;
  logic [DW-1:0]      PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

endinterface

// File: rtl/apb_shared_master_rr_pick.sv
// rtl/apb_shared_master_rr_pick.sv - combinational one-hot round-robin picker
module apb_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int          pos;
  logic [PW-1:0] sel;

  // Scan from ptr upward with wrap; the first valid requester wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      sel = PW'(pos);
      if (!any && req_valid[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/apb_shared_master.sv
// rtl/apb_shared_master.sv - round-robin sharing of one APB master port
module apb_shared_master
  import apb_shared_master_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  apb_shared_master_if.master bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_next;
  logic [NREQ-1:0] win_oh;
  logic          win_any;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          done;
  logic          grant_en;

  apb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .grant     (win_oh),
    .idx       (win_idx),
    .any       (win_any)
  );

  // PREADY has priority: a timeout only fires in an ACCESS cycle without it
  assign tmo_hit  = (TIMEOUT > 0) && (state == ACCESS) && !bus.PREADY
                    && (tmo_cnt == CW'(TIMEOUT - 1));
  assign done     = (state == ACCESS) && (bus.PREADY || tmo_hit);
  assign grant_en = ((state == IDLE) || done) && win_any;
  assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign bus.req_ready = grant_en ? win_oh : '0;

  // Phase sequencing, APB output registers and one-cycle response pulse
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      ptr           <= '0;
      gidx          <= '0;
      tmo_cnt       <= '0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      case (state)
        IDLE: ;
        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
          tmo_cnt     <= '0;
        end
        ACCESS: begin
          if (done) begin
            bus.rsp_valid <= NREQ'(1) << gidx;
            bus.rsp_err   <= tmo_hit | bus.PSLVERR;
            bus.rsp_rdata <= (tmo_hit || bus.PWRITE) ? '0 : bus.PRDATA;
            state         <= IDLE;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
          bus.PWRITE  <= 1'b0;
          bus.PADDR   <= '0;
          bus.PWDATA  <= '0;
        end
      endcase
      // A grant overrides the return to IDLE so back-to-back transfers skip it
      if (grant_en) begin
        state       <= SETUP;
        ptr         <= ptr_next;
        gidx        <= win_idx;
        bus.PSEL    <= 1'b1;
        bus.PENABLE <= 1'b0;
        bus.PWRITE  <= bus.req_write[win_idx];
        bus.PADDR   <= bus.req_addr[win_idx*AW +: AW];
        bus.PWDATA  <= bus.req_write[win_idx] ? bus.req_wdata[win_idx*DW +: DW] : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_shared_master.sv
// tb/tb_apb_shared_master.sv - directed self-checking bench for apb_shared_master
module tb_apb_shared_master;

  localparam int NREQ    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  apb_shared_master_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_shared_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_write[i]         = wr;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin errors++; $display("FAIL reset_sel_en: got %b want 00", {bus.PSEL, bus.PENABLE}); end
    checks++; if (bus.PADDR !== 32'h0) begin errors++; $display("FAIL reset_paddr: got %h want 0", bus.PADDR); end
    checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL reset_pwdata: got %h want 0", bus.PWDATA); end
    checks++; if ({bus.rsp_err, bus.PWRITE} !== 2'b00) begin errors++; $display("FAIL reset_err_pwrite: got %b want 00", {bus.rsp_err, bus.PWRITE}); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge PCLK);
    set_req(2, 1'b0, 32'h40, 32'h5555_5555);
    bus.req_valid = 4'b0100;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL read_grant: got %b want 0100", bus.req_ready); end
    checks++; if (bus.PSEL !== 1'b0) begin errors++; $display("FAIL read_c0_psel: got %b want 0", bus.PSEL); end
    @(negedge PCLK);
    bus.req_valid = 4'b0000;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'hDEAD_BEEF;
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b10) begin errors++; $display("FAIL read_setup: got %b want 10", {bus.PSEL, bus.PENABLE}); end
    checks++; if ({bus.PWRITE, bus.PADDR, bus.PWDATA} !== {1'b0, 32'h40, 32'h0}) begin errors++; $display("FAIL read_fields: got %b %h %h want 0 40 0", bus.PWRITE, bus.PADDR, bus.PWDATA); end
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL read_setup_ready: got %b want 0000", bus.req_ready); end
    @(negedge PCLK);
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin errors++; $display("FAIL read_access: got %b want 11", {bus.PSEL, bus.PENABLE}); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL read_early_rsp: got %b want 0000", bus.rsp_valid); end
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL read_rsp_valid: got %b want 0100", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata: got %h want deadbeef", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", bus.rsp_err); end
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PADDR} !== {2'b00, 32'h0}) begin errors++; $display("FAIL read_idle: got %b %b %h want 0 0 0", bus.PSEL, bus.PENABLE, bus.PADDR); end
    @(negedge PCLK);
    #1;
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL read_rsp_pulse: got %b want 0000", bus.rsp_valid); end
  endtask

  task automatic test_wait_error();
    @(negedge PCLK);
    set_req(1, 1'b1, 32'h8, 32'h1234);
    bus.req_valid = 4'b0010;
    bus.PREADY    = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL werr_grant: got %b want 0010", bus.req_ready); end
    @(negedge PCLK);
    bus.req_valid = 4'b0000;
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101) begin errors++; $display("FAIL werr_setup: got %b want 101", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      if (k == 3) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hCAFE_0000;
      end
      #1;
      checks++; if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA} !== {2'b11, 32'h8, 32'h1234}) begin errors++; $display("FAIL werr_stable%0d: got %b%b %h %h want 11 8 1234", k, bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA); end
      checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL werr_wait_rsp%0d: got %b want 0000", k, bus.rsp_valid); end
    end
    @(negedge PCLK);
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL werr_rsp_valid: got %b want 0010", bus.rsp_valid); end
    checks++; if ({bus.rsp_err, bus.rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL werr_err_rdata: got %b %h want 1 0", bus.rsp_err, bus.rsp_rdata); end
  endtask

  task automatic test_timeout();
    @(negedge PCLK);
    set_req(3, 1'b0, 32'h100, 32'h0);
    bus.req_valid = 4'b1000;
    bus.PRDATA    = 32'h1234_5678;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL tmo_grant: got %b want 1000", bus.req_ready); end
    @(negedge PCLK);
    bus.req_valid = 4'b0000;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge PCLK);
      #1;
      checks++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== {2'b11, 4'b0000}) begin errors++; $display("FAIL tmo_access%0d: got %b %b want 11 0000", k, {bus.PSEL, bus.PENABLE}, bus.rsp_valid); end
    end
    @(negedge PCLK);
    bus.PREADY = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL tmo_rsp_valid: got %b want 1000", bus.rsp_valid); end
    checks++; if ({bus.rsp_err, bus.rsp_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL tmo_err_rdata: got %b %h want 1 0", bus.rsp_err, bus.rsp_rdata); end
    checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin errors++; $display("FAIL tmo_idle: got %b want 00", {bus.PSEL, bus.PENABLE}); end
    @(negedge PCLK);
    #1;
    checks++; if ({bus.PSEL, bus.rsp_valid} !== {1'b0, 4'b0000}) begin errors++; $display("FAIL tmo_late_ready: got %b %b want 0 0000", bus.PSEL, bus.rsp_valid); end
    bus.PREADY = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge PCLK);
    set_req(1, 1'b0, 32'h20, 32'h0);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rst_grant: got %b want 0010", bus.req_ready); end
    @(negedge PCLK);
    bus.req_valid = 4'b0000;
    @(negedge PCLK);
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin errors++; $display("FAIL rst_access: got %b want 11", {bus.PSEL, bus.PENABLE}); end
    #2;
    PRESETn = 1'b0;
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin errors++; $display("FAIL rst_async_drop: got %b want 00", {bus.PSEL, bus.PENABLE}); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      #1;
      checks++; if ({bus.PSEL, bus.rsp_valid} !== {1'b0, 4'b0000}) begin errors++; $display("FAIL rst_no_rsp%0d: got %b %b want 0 0000", k, bus.PSEL, bus.rsp_valid); end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    @(negedge PCLK);
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h200 + 32'(i * 16), 32'h0);
    bus.req_valid = 4'b1111;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'hA0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge PCLK);
      #1;
      if (c % 2 == 0) begin
        exp = 4'b0001 << ((c / 2) % 4);
        checks++; if (bus.req_ready !== exp) begin errors++; $display("FAIL fair_grant_c%0d: got %b want %b", c, bus.req_ready, exp); end
      end else begin
        checks++; if ({bus.PSEL, bus.PENABLE, bus.req_ready} !== {2'b10, 4'b0000}) begin errors++; $display("FAIL fair_setup_c%0d: got %b %b want 10 0000", c, {bus.PSEL, bus.PENABLE}, bus.req_ready); end
        exp = (c >= 3) ? (4'b0001 << (((c - 3) / 2) % 4)) : 4'b0000;
        checks++; if (bus.rsp_valid !== exp) begin errors++; $display("FAIL fair_rsp_c%0d: got %b want %b", c, bus.rsp_valid, exp); end
      end
    end
    @(posedge PCLK);
    #1;
    bus.req_valid = 4'b0000;
    repeat (3) @(negedge PCLK);
    #1;
    checks++; if ({bus.PSEL, bus.rsp_valid} !== {1'b0, 4'b0001}) begin errors++; $display("FAIL fair_drain: got %b %b want 0 0001", bus.PSEL, bus.rsp_valid); end
    bus.PREADY = 1'b0;
  endtask

  task automatic test_withdraw();
    @(negedge PCLK);
    set_req(3, 1'b1, 32'h30, 32'h77);
    set_req(1, 1'b0, 32'h10, 32'h0);
    bus.req_valid = 4'b1000;
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wd_grant: got %b want 1000", bus.req_ready); end
    @(negedge PCLK);
    bus.req_valid = 4'b0010;
    #1;
    checks++; if ({bus.PSEL, bus.PENABLE, bus.req_ready} !== {2'b10, 4'b0000}) begin errors++; $display("FAIL wd_setup: got %b %b want 10 0000", {bus.PSEL, bus.PENABLE}, bus.req_ready); end
    @(negedge PCLK);
    bus.req_valid = 4'b0000;
    bus.PREADY    = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL wd_no_grant: got %b want 0000", bus.req_ready); end
    @(negedge PCLK);
    bus.PREADY = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL wd_rsp: got %b want 1000", bus.rsp_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge PCLK);
      #1;
      checks++; if ({bus.PSEL, bus.rsp_valid} !== {1'b0, 4'b0000}) begin errors++; $display("FAIL wd_quiet%0d: got %b %b want 0 0000", k, bus.PSEL, bus.rsp_valid); end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    test_reset();
    test_single_read();
    test_wait_error();
    test_timeout();
    test_reset_mid_access();
    test_fairness();
    test_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
